seed_random_2_card_dealer: RTL

Parametrised successor to the single-deck seed counter. It keeps a free-running 16-bit LFSR as the entropy source and deals cards on request from a shoe of NUM_DECKS decks. A dealt-card table guarantees no card is dealt more times than the shoe holds. It sits between the game FSM (request/valid handshake) and the hand-scoring datapath.

---
 rtl/seed_random_2_card_dealer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/seed_random_2_card_dealer.sv
// Multi-deck card dealer. A free-running 16-bit Galois LFSR supplies the
// entropy; a per-card usage table caps every card at NUM_DECKS deals per shoe.
//
// state | meaning
// IDLE  | waiting for a request or a shuffle
// CHECK | probing the usage table from the reduced LFSR index
// DONE  | card committed; the valid pulse follows on the next cycle
module seed_random_2_card_dealer #(
   parameter int          NUM_DECKS = 1,
   parameter logic [15:0] SEED      = 16'hACE1
) (
   input  logic       clk_dp_i,
   input  logic       rst_dp_i,
   input  logic       req_card_i,
   input  logic       shuffle_i,
   output logic [7:0] card_to_send_o,
   output logic       card_valid_o,
   output logic       empty_o,
   output logic       busy_o,
   output logic [8:0] cards_left_o
);

   localparam logic [1:0]  ST_IDLE   = 2'd0;
   localparam logic [1:0]  ST_CHECK  = 2'd1;
   localparam logic [1:0]  ST_DONE   = 2'd2;
   localparam logic [8:0]  FULL_SHOE = 9'(52 * NUM_DECKS);
   localparam logic [3:0]  DECK_CNT  = 4'(NUM_DECKS);
   localparam logic [15:0] LFSR_MASK = 16'hB400;

   logic [1:0]  state_q, state_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [5:0]  idx_q, idx_d;
   logic [7:0]  card_q, card_d;
   logic [8:0]  left_q, left_d;
   logic        valid_q, valid_d;
   logic        empty_q, empty_d;
   logic        clear_tbl;
   logic        inc_tbl;
   logic [3:0]  used_q [52];
   logic [5:0]  raw_idx;
   logic [5:0]  red_idx;

   // Map a 0..51 index to {00, suit, rank} without a divider.
   function automatic logic [7:0] encode(input logic [5:0] idx);
      logic [1:0] suit;
      logic [5:0] rem;
      if (idx >= 6'd39) begin
         suit = 2'd3;
         rem  = idx - 6'd39;
      end else if (idx >= 6'd26) begin
         suit = 2'd2;
         rem  = idx - 6'd26;
      end else if (idx >= 6'd13) begin
         suit = 2'd1;
         rem  = idx - 6'd13;
      end else begin
         suit = 2'd0;
         rem  = idx;
      end
      return {2'b00, suit, rem[3:0] + 4'd1};
   endfunction

   // Galois step and fold of the low six bits into 0..51 (bias accepted).
   always_comb begin
      lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
      raw_idx = lfsr_q[5:0];
      red_idx = (raw_idx >= 6'd52) ? raw_idx - 6'd52 : raw_idx;
   end

   // Dealer FSM next-state and datapath control.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      card_d    = card_q;
      left_d    = left_q;
      valid_d   = 1'b0;
      empty_d   = 1'b0;
      clear_tbl = 1'b0;
      inc_tbl   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (shuffle_i) begin
               clear_tbl = 1'b1;
               left_d    = FULL_SHOE;
            end else if (req_card_i) begin
               idx_d   = red_idx;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (left_q == 9'd0) begin
               empty_d = 1'b1;
               state_d = ST_IDLE;
            end else if (used_q[idx_q] < DECK_CNT) begin
               inc_tbl = 1'b1;
               left_d  = left_q - 9'd1;
               card_d  = encode(idx_q);
               state_d = ST_DONE;
            end else begin
               // A free slot is guaranteed while cards remain, so the probe ends.
               idx_d = (idx_q == 6'd51) ? 6'd0 : idx_q + 6'd1;
            end
         end
         ST_DONE: begin
            valid_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and datapath registers; the LFSR runs in every state.
   always_ff @(posedge clk_dp_i or negedge rst_dp_i) begin
      if (!rst_dp_i) begin
         state_q <= ST_IDLE;
         lfsr_q  <= SEED;
         idx_q   <= 6'd0;
         card_q  <= 8'd0;
         left_q  <= FULL_SHOE;
         valid_q <= 1'b0;
         empty_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         idx_q   <= idx_d;
         card_q  <= card_d;
         left_q  <= left_d;
         valid_q <= valid_d;
         empty_q <= empty_d;
      end
   end

   // Per-card deal counts for the current shoe.
   always_ff @(posedge clk_dp_i or negedge rst_dp_i) begin
      if (!rst_dp_i) begin
         for (int i = 0; i < 52; i++) used_q[i] <= 4'd0;
      end else if (clear_tbl) begin
         for (int i = 0; i < 52; i++) used_q[i] <= 4'd0;
      end else if (inc_tbl) begin
         used_q[idx_q] <= used_q[idx_q] + 4'd1;
      end
   end

   assign card_to_send_o = card_q;
   assign card_valid_o   = valid_q;
   assign empty_o        = empty_q;
   assign busy_o         = (state_q != ST_IDLE);
   assign cards_left_o   = left_q;

endmodule
